fifo_top_sc: RTL and testbench
==============================

Name: fifo_top_sc

Overview:
- Single-clock synchronous FIFO with a registered storage array and binary read/write pointers.
- Provides full, empty, almost-full and almost-empty status flags.
- Serves as a rate-decoupling buffer between a producer and a consumer in the same clock domain.
- First-word-fall-through read port: the head entry is always visible on rdata.

Parameters:
- DATASIZE, 8, data word width in bits.
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE (16 entries).
- ALMOST_TH, 2, distance from full/empty at which the almost flags assert; legal range 1..DEPTH/2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wdata  in  DATASIZE  write data.
- winc  in  1  write request.
- wfull  out  1  FIFO holds DEPTH entries.
- walmost_full  out  1  count >= DEPTH-ALMOST_TH.
- rinc  in  1  read request (pop).
- rdata  out  DATASIZE  head-of-FIFO data, combinational from memory at the read address.
- rempty  out  1  FIFO holds 0 entries.
- ralmost_empty  out  1  count <= ALMOST_TH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named clk and rst.
- State:
  - waddr and raddr pointers of ADDRSIZE+1 bits; the MSB is the wrap bit.
  - Memory is DEPTH x DATASIZE.
  - count = (wptr - rptr) modulo 2**(ADDRSIZE+1), range 0..DEPTH.
- Reset (rst=1, asynchronous):
  - Pointers cleared to 0 and memory cleared to 0, so rdata=0.
  - rempty=1, ralmost_empty=1, wfull=0, walmost_full=0.
  - Outputs hold these values for as long as rst is high.
  - Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Write:
  - Accepted on a rising edge when winc=1 and wfull=0.
  - The word is stored at mem[wptr[ADDRSIZE-1:0]] and wptr increments.
  - Writes with wfull=1 are dropped silently; no state changes.
- Read:
  - Accepted on a rising edge when rinc=1 and rempty=0; rptr increments.
  - rdata = mem[rptr[ADDRSIZE-1:0]] at all times.
  - Latency is zero: the popped word is on rdata before the edge that pops it.
  - After the pop, the next entry appears on rdata in the same cycle the pointer updates.
  - Reads with rempty=1 are ignored.
  - rdata is don't-care while rempty=1, but keeps the stale memory value; no X.
- Simultaneous winc and rinc:
  - Each side is qualified independently by its own flag.
  - Not full and not empty: both occur and count is unchanged.
  - Empty: only the write occurs and count becomes 1.
  - Full: only the read occurs and count becomes DEPTH-1.
- Wrap-around:
  - Pointers roll over from 2**(ADDRSIZE+1)-1 to 0.
  - Address bits index memory modulo DEPTH.
  - Ordering is preserved indefinitely.
- Flags:
  - Registered; they reflect the post-edge state in the cycle after the causing edge.
  - Each is computed from the next-state pointers, so it updates on the same edge as the pointers.
  - wfull = (wptr[MSB] != rptr[MSB]) and the lower address bits are equal.
  - rempty = (wptr == rptr).
  - walmost_full stays high while full.
  - ralmost_empty stays high while empty.
  - No flag glitches, since all flags are flop outputs.

Decomposition:
- Package fifo_pkg:
  - Default DATASIZE/ADDRSIZE/ALMOST_TH constants.
  - A helper function computing count from two pointers.
- One sub-module fifo_mem:
  - DEPTH x DATASIZE array with a synchronous write port (wen, waddr, wdata).
  - Asynchronous read port (raddr, rdata) and reset clear.
- Pointer, count and flag logic stays in the top module.

Test Plan:
- Reset: assert rst for 2 cycles mid-run -> rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, rdata=0 immediately; prior contents lost.
- Fill: 16 writes of 0x00..0x0F with rinc=0.
  - walmost_full rises after the 14th write (count 14).
  - wfull rises after the 16th.
  - A 17th write of 0xFF is dropped.
- Drain: rinc=1 from full.
  - rdata sequence is 0x00..0x0F.
  - wfull drops after the first pop and walmost_full drops when count reaches 13.
  - ralmost_empty rises at count 2 and rempty rises after the 16th pop.
  - A further rinc leaves the pointers unchanged.
- Simultaneous at empty: winc=rinc=1 with an incrementing wdata.
  - First edge: write only, count 1.
  - Subsequent edges: count stays 1 and rdata follows the writes in order, one behind.
- Simultaneous at full: winc=rinc=1 -> read proceeds, write blocked, count 15, wfull=0 next cycle.
- Wrap: push/pop 40 words at count 5 -> every rdata matches the written sequence across pointer rollover; flags are correct throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared defaults and pointer helper for fifo_top_sc         |
// | Rev 1.0  : initial release                                            |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int c_DATASIZE_DEF  = 8;
    localparam int c_ADDRSIZE_DEF  = 4;
    localparam int c_ALMOST_TH_DEF = 2;

    // Occupancy from two wrap-bit pointers, zero-extended to 32 bits by the caller.
    function automatic logic [31:0] fifo_count(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int          addrsize);
        logic [31:0] mask;
        mask = (32'd1 << (addrsize + 1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem : DEPTH x DATASIZE array, sync write, async read, reset clear|
// | Rev 1.0  : initial release                                            |
// +----------------------------------------------------------------------+
module fifo_mem #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int c_DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem_q [c_DEPTH];
    logic [DATASIZE-1:0] mem_d [c_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wen) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_top_sc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_top_sc : single-clock FWFT FIFO with registered status flags     |
// | Rev 1.0     : initial release                                         |
// +----------------------------------------------------------------------+
module fifo_top_sc
    import fifo_pkg::*;
#(
    parameter int DATASIZE  = c_DATASIZE_DEF,
    parameter int ADDRSIZE  = c_ADDRSIZE_DEF,
    parameter int ALMOST_TH = c_ALMOST_TH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                winc,
    output logic                wfull,
    output logic                walmost_full,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic                ralmost_empty
);

    localparam int c_DEPTH = 1 << ADDRSIZE;

    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic              wfull_q, wfull_d;
    logic              rempty_q, rempty_d;
    logic              walmost_full_q, walmost_full_d;
    logic              ralmost_empty_q, ralmost_empty_d;
    logic              wr_en, rd_en;
    logic [31:0]       count_d;

    // Each side is qualified only by its own flag, so a write into a full
    // FIFO stays blocked even when a read frees a slot on the same edge.
    assign wr_en = winc & ~wfull_q;
    assign rd_en = rinc & ~rempty_q;

    always_comb begin
        wptr_d = wptr_q + {{ADDRSIZE{1'b0}}, wr_en};
        rptr_d = rptr_q + {{ADDRSIZE{1'b0}}, rd_en};
        count_d = fifo_count({{(31-ADDRSIZE){1'b0}}, wptr_d},
                             {{(31-ADDRSIZE){1'b0}}, rptr_d}, ADDRSIZE);
        wfull_d = (wptr_d[ADDRSIZE] != rptr_d[ADDRSIZE]) &&
                  (wptr_d[ADDRSIZE-1:0] == rptr_d[ADDRSIZE-1:0]);
        rempty_d        = (wptr_d == rptr_d);
        walmost_full_d  = (count_d >= 32'(c_DEPTH - ALMOST_TH));
        ralmost_empty_d = (count_d <= 32'(ALMOST_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            wfull_q         <= wfull_d;
            rempty_q        <= rempty_d;
            walmost_full_q  <= walmost_full_d;
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    fifo_mem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wen   (wr_en),
        .waddr (wptr_q[ADDRSIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ADDRSIZE-1:0]),
        .rdata (rdata)
    );

    assign wfull         = wfull_q;
    assign rempty        = rempty_q;
    assign walmost_full  = walmost_full_q;
    assign ralmost_empty = ralmost_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_top_sc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_top_sc : directed + random bench against a queue model        |
// | Rev 1.0        : initial release                                      |
// +----------------------------------------------------------------------+
module tb_fifo_top_sc;

    localparam int c_DEPTH = 16;
    localparam int c_TH    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic       wfull, walmost_full, rempty, ralmost_empty;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;
    logic [7:0] model_q [$];
    logic [7:0] seq;

    always #5 clk = ~clk;

    fifo_top_sc u_dut (
        .clk           (clk),
        .rst           (rst),
        .wdata         (wdata),
        .winc          (winc),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rinc          (rinc),
        .rdata         (rdata),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t, model count=%0d)", tag, got, exp,
                     $time, model_q.size());
        end
    endtask

    task automatic check_flags();
        int n;
        n = model_q.size();
        check("rempty",        32'(rempty),        32'(n == 0));
        check("wfull",         32'(wfull),         32'(n == c_DEPTH));
        check("walmost_full",  32'(walmost_full),  32'(n >= c_DEPTH - c_TH));
        check("ralmost_empty", 32'(ralmost_empty), 32'(n <= c_TH));
        if (n > 0) check("rdata", 32'(rdata), 32'(model_q[0]));
    endtask

    // Called just after a falling edge: drive, check pre-edge state, clock, update model.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        bit wr_ok, rd_ok;
        winc  = w;
        wdata = d;
        rinc  = r;
        #1;
        check_flags();
        wr_ok = w && (model_q.size() < c_DEPTH);
        rd_ok = r && (model_q.size() > 0);
        @(posedge clk);
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rempty"},  32'(rempty),        32'd1);
        check({tag, "_raempty"}, 32'(ralmost_empty), 32'd1);
        check({tag, "_wfull"},   32'(wfull),         32'd0);
        check({tag, "_wafull"},  32'(walmost_full),  32'd0);
        check({tag, "_rdata"},   32'(rdata),         32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Fill with 0x00..0x0F, then a dropped 0xFF
        for (int i = 0; i < c_DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        check("fill_count", 32'(model_q.size()), 32'd16);
        #1; check_flags();

        // Drain to empty plus one extra read
        for (int i = 0; i < c_DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);
        #1; check_flags();

        // Simultaneous at empty
        seq = 8'h40;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, seq, 1'b1);
            seq++;
        end
        check("sim_empty_count", 32'(model_q.size()), 32'd1);

        // Fill, then simultaneous at full
        while (model_q.size() < c_DEPTH) begin
            cycle(1'b1, seq, 1'b0);
            seq++;
        end
        cycle(1'b1, 8'hEE, 1'b1);
        check("sim_full_count", 32'(model_q.size()), 32'd15);
        #1; check_flags();

        // Down to count 5, then 40 push/pop words across pointer rollover
        while (model_q.size() > 5) cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, seq, 1'b1);
            seq++;
        end
        check("wrap_count", 32'(model_q.size()), 32'd5);

        // Random traffic with shifting write/read bias
        for (int i = 0; i < 600; i++) begin
            int wb;
            wb = ((i / 100) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(0, 99) < wb), 8'($urandom), ($urandom_range(0, 99) < 50));
        end

        // Make sure the FIFO has contents, then assert reset between edges
        while (model_q.size() < 8) cycle(1'b1, 8'($urandom), 1'b0);
        winc = 1'b0;
        rinc = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);

        // Post-reset: prior contents gone, FIFO works normally
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        #1; check_flags();
        check("post_rst_count", 32'(model_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
